// File: rtl/sme_pkg.sv
// Shared definitions for the string-match engine and its host-side feeder:
// special pattern characters, buffer depths, feeder states and result codes.
package sme_pkg;

    // Pattern metacharacters understood by the match engine
    localparam logic [7:0] HAT    = 8'h5E;
    localparam logic [7:0] DOT    = 8'h2E;
    localparam logic [7:0] DOLLAR = 8'h24;
    localparam logic [7:0] SPACE  = 8'h20;
    localparam logic [7:0] STAR   = 8'h2A;

    // Engine buffer depths
    localparam int STR_MAX = 32;
    localparam int PAT_MAX = 8;

    // Feeder job sequencing
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SEND_STR = 3'd1,
        S_SEND_PAT = 3'd2,
        S_GAP      = 3'd3,
        S_WAIT     = 3'd4,
        S_RESULT   = 3'd5
    } feeder_state_t;

    // Result status returned to the host
    typedef enum logic [1:0] {
        ST_OK      = 2'b00,
        ST_TIMEOUT = 2'b01,
        ST_LEN_ERR = 2'b10
    } res_status_t;

endpackage

// File: rtl/sme_char_buf.sv
// Small character buffer: synchronous write, asynchronous read, cleared by reset.
module sme_char_buf #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    // Store one character per write strobe; reset wipes every entry
    // NOTE: this memory is reset on purpose (the host relies on cleared buffers), which rules out RAM-macro inference; only do this for small register-file buffers.
    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sme_job_feeder.sv
// Host-side job feeder for the string-match engine: buffers one string and
// one pattern, streams them to the engine, waits for its result (with a
// timeout) and hands the result to the host through a valid/ready port.
module sme_job_feeder #(
    parameter int STR_MAX = sme_pkg::STR_MAX,
    parameter int PAT_MAX = sme_pkg::PAT_MAX,
    parameter int TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic       wr_sel,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       start,
    input  logic [5:0] str_len,
    input  logic [3:0] pat_len,
    input  logic       keep_str,
    output logic       busy,
    output logic [7:0] chardata,
    output logic       isstring,
    output logic       ispattern,
    input  logic       eng_valid,
    input  logic       eng_match,
    input  logic [4:0] eng_index,
    output logic       res_valid,
    input  logic       res_ready,
    output logic       res_match,
    output logic [4:0] res_index,
    output logic [1:0] res_status
);
    import sme_pkg::*;

    localparam int CW = $clog2(TIMEOUT + 1);

    feeder_state_t state_q, state_n;
    logic [5:0]    idx_q, idx_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic [5:0]    str_len_q;
    logic [3:0]    pat_len_q;
    logic          len_ok;
    logic          cap_en;
    logic          cap_match;
    logic [4:0]    cap_index;
    res_status_t   cap_status;
    logic [7:0]    str_rdata, pat_rdata;

    // Pattern length must always be legal; string length only matters when it is sent
    assign len_ok = (pat_len != 4'd0) && (pat_len <= 4'(PAT_MAX)) &&
                    (keep_str || ((str_len != 6'd0) && (str_len <= 6'(STR_MAX))));

    sme_char_buf #(.DEPTH(STR_MAX)) u_str_buf (
        .clk   (clk),
        .reset (reset),
        .we    (wr_en && !busy && !wr_sel),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (idx_n[4:0]),
        .rdata (str_rdata)
    );

    sme_char_buf #(.DEPTH(PAT_MAX)) u_pat_buf (
        .clk   (clk),
        .reset (reset),
        .we    (wr_en && !busy && wr_sel),
        .waddr (wr_addr[2:0]),
        .wdata (wr_data),
        .raddr (idx_n[2:0]),
        .rdata (pat_rdata)
    );

    // Next-state, char index, wait counter and result-capture decisions
    // NOTE: every signal gets a default before the case so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        state_n    = state_q;
        idx_n      = idx_q;
        cnt_n      = cnt_q;
        cap_en     = 1'b0;
        cap_match  = 1'b0;
        cap_index  = 5'd0;
        cap_status = ST_OK;
        case (state_q)
            S_IDLE: begin
                idx_n = 6'd0;
                if (start) begin
                    if (len_ok) begin
                        state_n = keep_str ? S_SEND_PAT : S_SEND_STR;
                    end else begin
                        state_n    = S_RESULT;
                        cap_en     = 1'b1;
                        cap_status = ST_LEN_ERR;
                    end
                end
            end
            S_SEND_STR: begin
                if (idx_q == str_len_q - 6'd1) begin
                    state_n = S_SEND_PAT;
                    idx_n   = 6'd0;
                end else begin
                    idx_n = idx_q + 6'd1;
                end
            end
            S_SEND_PAT: begin
                if (idx_q == {2'b00, pat_len_q} - 6'd1) begin
                    state_n = S_GAP;
                    idx_n   = 6'd0;
                end else begin
                    idx_n = idx_q + 6'd1;
                end
            end
            S_GAP: begin
                state_n = S_WAIT;
                cnt_n   = '0;
            end
            S_WAIT: begin
                if (eng_valid) begin
                    state_n   = S_RESULT;
                    cap_en    = 1'b1;
                    cap_match = eng_match;
                    cap_index = eng_index;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_n    = S_RESULT;
                    cap_en     = 1'b1;
                    cap_status = ST_TIMEOUT;
                end else begin
                    cnt_n = cnt_q + CW'(1);
                end
            end
            S_RESULT: begin
                if (res_ready) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State, job parameters and registered engine/host outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            idx_q      <= 6'd0;
            cnt_q      <= '0;
            str_len_q  <= 6'd0;
            pat_len_q  <= 4'd0;
            busy       <= 1'b0;
            chardata   <= 8'h00;
            isstring   <= 1'b0;
            ispattern  <= 1'b0;
            res_valid  <= 1'b0;
            res_match  <= 1'b0;
            res_index  <= 5'd0;
            res_status <= 2'b00;
        end else begin
            state_q   <= state_n;
            idx_q     <= idx_n;
            cnt_q     <= cnt_n;
            if (state_q == S_IDLE && start && len_ok) begin
                str_len_q <= str_len;
                pat_len_q <= pat_len;
            end
            busy      <= (state_n != S_IDLE);
            isstring  <= (state_n == S_SEND_STR);
            ispattern <= (state_n == S_SEND_PAT);
            chardata  <= (state_n == S_SEND_STR) ? str_rdata :
                         (state_n == S_SEND_PAT) ? pat_rdata : 8'h00;
            res_valid <= (state_n == S_RESULT);
            if (cap_en) begin
                res_match  <= cap_match;
                res_index  <= cap_index;
                res_status <= cap_status;
            end
        end
    end

endmodule

// File: tb/tb_sme_job_feeder.sv
// Self-checking bench for sme_job_feeder: directed scenarios plus randomized
// jobs, compared against a character-stream model built from buffer images.
module tb_sme_job_feeder;

    localparam int TIMEOUT = 16;
    localparam int STR_MAX = 32;
    localparam int PAT_MAX = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en, wr_sel;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       start;
    logic [5:0] str_len;
    logic [3:0] pat_len;
    logic       keep_str;
    logic       busy;
    logic [7:0] chardata;
    logic       isstring, ispattern;
    logic       eng_valid, eng_match;
    logic [4:0] eng_index;
    logic       res_valid, res_ready, res_match;
    logic [4:0] res_index;
    logic [1:0] res_status;

    int checks = 0;
    int errors = 0;

    // Host-visible model: buffer images and the result the current job must return
    logic [7:0] m_str [STR_MAX];
    logic [7:0] m_pat [PAT_MAX];
    logic       exp_match;
    logic [4:0] exp_index;
    logic [1:0] exp_status;

    sme_job_feeder #(.STR_MAX(STR_MAX), .PAT_MAX(PAT_MAX), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .str_len    (str_len),
        .pat_len    (pat_len),
        .keep_str   (keep_str),
        .busy       (busy),
        .chardata   (chardata),
        .isstring   (isstring),
        .ispattern  (ispattern),
        .eng_valid  (eng_valid),
        .eng_match  (eng_match),
        .eng_index  (eng_index),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_match  (res_match),
        .res_index  (res_index),
        .res_status (res_status)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge
    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < STR_MAX; i++) m_str[i] = 8'h00;
        for (int i = 0; i < PAT_MAX; i++) m_pat[i] = 8'h00;
    endtask

    task automatic wr(input bit sel, input logic [4:0] addr, input logic [7:0] d);
        wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = d;
        adv();
        wr_en = 1'b0;
        if (sel) m_pat[addr[2:0]] = d;
        else     m_str[addr] = d;
    endtask

    task automatic check_result_fields(input string tag);
        check({tag, "_valid"},  res_valid,  1);
        check({tag, "_match"},  res_match,  exp_match);
        check({tag, "_index"},  res_index,  exp_index);
        check({tag, "_status"}, res_status, exp_status);
    endtask

    // Launch one job and follow it up to the cycle where the result appears
    task automatic run_job(input int sl, input int pl, input bit keep, input bit respond,
                           input int delay, input bit m, input logic [4:0] ix);
        logic [9:0] exp_q [$];
        bit legal;
        int n;
        legal = (pl >= 1) && (pl <= PAT_MAX) && (keep || ((sl >= 1) && (sl <= STR_MAX)));
        str_len = 6'(sl); pat_len = 4'(pl); keep_str = keep; start = 1'b1;
        adv();
        start = 1'b0;
        if (!legal) begin
            exp_match = 1'b0; exp_index = 5'd0; exp_status = 2'b10;
            check("lenerr_strobes", {isstring, ispattern}, 0);
            check("lenerr_busy", busy, 1);
            check_result_fields("lenerr");
            return;
        end
        if (!keep) for (int k = 0; k < sl; k++) exp_q.push_back({2'b10, m_str[k]});
        for (int k = 0; k < pl; k++) exp_q.push_back({2'b01, m_pat[k]});
        exp_q.push_back(10'h000);
        foreach (exp_q[i]) begin
            check("stream", {isstring, ispattern, chardata}, exp_q[i]);
            check("busy_job", busy, 1);
            adv();
        end
        if (respond) begin
            for (int i = 0; i < delay; i++) begin
                check("wait_quiet", {res_valid, isstring, ispattern}, 0);
                adv();
            end
            eng_valid = 1'b1; eng_match = m; eng_index = ix;
            adv();
            eng_valid = 1'b0; eng_match = 1'b0; eng_index = 5'd0;
            exp_match = m; exp_index = ix; exp_status = 2'b00;
            check_result_fields("ok");
        end else begin
            n = 0;
            while (res_valid !== 1'b1 && n < 100) begin
                check("timeout_quiet", {isstring, ispattern, chardata}, 0);
                n++;
                adv();
            end
            check("timeout_cycles", n, TIMEOUT);
            exp_match = 1'b0; exp_index = 5'd0; exp_status = 2'b01;
            check_result_fields("timeout");
        end
    endtask

    // Hold the result for a while (with disturbances), then consume it
    task automatic finish_result(input int hold);
        for (int i = 0; i < hold; i++) begin
            res_ready = 1'b0;
            eng_valid = (i == 3); eng_match = ~exp_match; eng_index = ~exp_index;
            wr_en = (i == 5); wr_sel = 1'b0; wr_addr = 5'd0; wr_data = ~m_str[0];
            start = (i == 7); str_len = 6'd1; pat_len = 4'd1; keep_str = 1'b0;
            adv();
            eng_valid = 1'b0; wr_en = 1'b0; start = 1'b0;
            check_result_fields("hold");
            check("hold_busy", busy, 1);
            check("hold_strobes", {isstring, ispattern}, 0);
        end
        res_ready = 1'b1; start = 1'b1; str_len = 6'd1; pat_len = 4'd1; keep_str = 1'b0;
        adv();
        res_ready = 1'b0; start = 1'b0;
        check("done_valid", res_valid, 0);
        check("done_busy", busy, 0);
        adv();
        check("idle_after_hs", {busy, isstring, ispattern}, 0);
    endtask

    initial begin
        reset = 1'b1;
        wr_en = 1'b0; wr_sel = 1'b0; wr_addr = 5'd0; wr_data = 8'h00;
        start = 1'b0; str_len = 6'd0; pat_len = 4'd0; keep_str = 1'b0;
        eng_valid = 1'b0; eng_match = 1'b0; eng_index = 5'd0; res_ready = 1'b0;
        clear_model();
        #12;
        check("reset_outputs", {busy, isstring, ispattern, chardata, res_valid,
                                res_match, res_index, res_status}, 0);
        #1 reset = 1'b0;
        adv();
        check("idle_outputs", {busy, isstring, ispattern, res_valid}, 0);

        // Basic job: "abcde" against "cd", engine reports match at 2
        for (int i = 0; i < 5; i++) wr(1'b0, 5'(i), 8'h61 + 8'(i));
        wr(1'b1, 5'd0, 8'h63);
        wr(1'b1, 5'd1, 8'h64);
        run_job(5, 2, 1'b0, 1'b1, 3, 1'b1, 5'd2);
        finish_result(0);

        // Reuse the loaded string, pattern "^a$" with str_len 0
        wr(1'b1, 5'd0, sme_pkg::HAT);
        wr(1'b1, 5'd1, 8'h61);
        wr(1'b1, 5'd2, sme_pkg::DOLLAR);
        run_job(0, 3, 1'b1, 1'b1, 0, 1'b0, 5'd7);
        finish_result(1);

        // No engine response: timeout after TIMEOUT wait cycles
        run_job(2, 1, 1'b0, 1'b0, 0, 1'b0, 5'd0);
        finish_result(0);

        // eng_valid on the very last wait cycle beats the timeout
        run_job(1, 1, 1'b0, 1'b1, TIMEOUT - 1, 1'b1, 5'd31);
        finish_result(0);

        // Illegal lengths, then a long hold with ignored start/write/eng_valid
        run_job(4, 0, 1'b0, 1'b1, 0, 1'b0, 5'd0);
        finish_result(10);
        run_job(33, 3, 1'b0, 1'b1, 0, 1'b0, 5'd0);
        finish_result(0);
        run_job(0, 2, 1'b0, 1'b1, 0, 1'b0, 5'd0);
        finish_result(0);
        run_job(5, 9, 1'b0, 1'b1, 0, 1'b0, 5'd0);
        finish_result(0);

        // Full-length job: string buffer retained its contents (write while busy ignored)
        for (int i = 5; i < STR_MAX; i++) wr(1'b0, 5'(i), 8'($urandom));
        for (int i = 0; i < PAT_MAX; i++) wr(1'b1, 5'(i), 8'($urandom));
        run_job(STR_MAX, PAT_MAX, 1'b0, 1'b1, 2, 1'b0, 5'd9);
        finish_result(2);

        // Randomized jobs
        for (int j = 0; j < 10; j++) begin
            int nw;
            nw = $urandom_range(0, 6);
            for (int w = 0; w < nw; w++) wr(1'($urandom), 5'($urandom), 8'($urandom));
            run_job($urandom_range(1, STR_MAX), $urandom_range(1, PAT_MAX),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0),
                    $urandom_range(0, TIMEOUT - 1), 1'($urandom), 5'($urandom));
            finish_result($urandom_range(0, 3));
        end

        // Reset during the fourth string character
        str_len = 6'd5; pat_len = 4'd2; keep_str = 1'b0; start = 1'b1;
        adv();
        start = 1'b0;
        adv(); adv(); adv();
        check("pre_reset_char3", {isstring, chardata}, {1'b1, m_str[3]});
        #2 reset = 1'b1;
        #1;
        check("reset_mid_strobes", {isstring, ispattern, chardata}, 0);
        check("reset_mid_result", {res_valid, busy}, 0);
        #2 reset = 1'b0;
        clear_model();
        adv();
        check("post_reset_idle", {busy, isstring, ispattern, res_valid}, 0);
        run_job(4, 2, 1'b0, 1'b1, 1, 1'b1, 5'd4);
        finish_result(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the bench always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
